// File: rtl/lsu_if.sv
// Handshake and memory-port bundle between execute, load/store,
// writeback and the data memory.
interface lsu_if #(
    parameter int WIDTH = 32
);
    logic                   exu_valid;
    logic [3*WIDTH+11:0]    exu_data;
    logic                   lsu_ready;
    logic                   lsu_valid;
    logic [WIDTH+5:0]       lsu_data;
    logic                   wbu_ready;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_wen;
    logic [WIDTH-1:0]       mem_addr;
    logic [WIDTH-1:0]       mem_wdata;
    logic [WIDTH/8-1:0]     mem_wmask;
    logic                   mem_resp_valid;
    logic                   mem_resp_ready;
    logic [WIDTH-1:0]       mem_rdata;

    modport slave (
        input  exu_valid, exu_data, wbu_ready,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output lsu_ready, lsu_valid, lsu_data,
        output mem_req_valid, mem_req_wen, mem_addr,
        output mem_wdata, mem_wmask, mem_resp_ready
    );

    modport master (
        output exu_valid, exu_data, wbu_ready,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  lsu_ready, lsu_valid, lsu_data,
        input  mem_req_valid, mem_req_wen, mem_addr,
        input  mem_wdata, mem_wmask, mem_resp_ready
    );
endinterface

// File: rtl/lsu.sv
// Load/store stage: one memory transaction per instruction, store lane
// alignment, load extraction/extension and writeback value selection.
module lsu #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_OUT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3*WIDTH+11:0] pl;
    logic [WIDTH-1:0]    rdata_q;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] rs2_data;
    logic [2:0]       funct3;
    logic             mem_ren;
    logic             mem_wen;
    logic             reg_wen;
    logic [4:0]       rd;
    logic             csr_sel;
    logic [WIDTH-1:0] csr_data;

    assign alu_result = pl[3*WIDTH+11 -: WIDTH];
    assign rs2_data   = pl[2*WIDTH+11 -: WIDTH];
    assign funct3     = pl[WIDTH+11:WIDTH+9];
    assign mem_ren    = pl[WIDTH+8];
    assign mem_wen    = pl[WIDTH+7];
    assign reg_wen    = pl[WIDTH+6];
    assign rd         = pl[WIDTH+5:WIDTH+1];
    assign csr_sel    = pl[WIDTH];
    assign csr_data   = pl[WIDTH-1:0];

    logic accept;
    logic resp_take;

    assign accept    = bus.exu_valid & (state == S_IDLE);
    assign resp_take = bus.mem_resp_valid & (state == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pl      <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                pl <= bus.exu_data;
            if (resp_take)
                rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nxt          = state;
        bus.lsu_ready      = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_resp_ready = 1'b0;
        bus.lsu_valid      = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.lsu_ready = 1'b1;
                if (bus.exu_valid) begin
                    if (bus.exu_data[WIDTH+8] | bus.exu_data[WIDTH+7])
                        state_nxt = S_REQ;
                    else
                        state_nxt = S_OUT;
                end
            end
            S_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.mem_resp_ready = 1'b1;
                if (bus.mem_resp_valid)
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                bus.lsu_valid = 1'b1;
                if (bus.wbu_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    logic [1:0] off;
    logic [4:0] sh;

    assign off = alu_result[1:0];
    assign sh  = {off, 3'b000};

    logic [3:0]       wmask;
    logic [WIDTH-1:0] wdata;

    // Reads never assert byte enables; unknown store widths still issue.
    always_comb begin
        wmask = 4'b0000;
        wdata = rs2_data;
        if (mem_wen) begin
            unique case (funct3)
                3'b000: begin
                    wmask = 4'b0001 << off;
                    wdata = {{(WIDTH-8){1'b0}}, rs2_data[7:0]} << sh;
                end
                3'b001: begin
                    wmask = 4'b0011 << off;
                    wdata = {{(WIDTH-16){1'b0}}, rs2_data[15:0]} << sh;
                end
                3'b010: begin
                    wmask = 4'b1111;
                    wdata = rs2_data;
                end
                default: wmask = 4'b0000;
            endcase
        end
    end

    assign bus.mem_req_wen = mem_wen;
    assign bus.mem_addr    = alu_result;
    assign bus.mem_wdata   = wdata;
    assign bus.mem_wmask   = wmask;

    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] wb_data;

    assign word = rdata_q >> sh;

    always_comb begin
        ld_data = '0;
        unique case (funct3)
            3'b000: ld_data = {{(WIDTH-8){word[7]}}, word[7:0]};
            3'b100: ld_data = {{(WIDTH-8){1'b0}}, word[7:0]};
            3'b001: ld_data = {{(WIDTH-16){word[15]}}, word[15:0]};
            3'b101: ld_data = {{(WIDTH-16){1'b0}}, word[15:0]};
            3'b010: ld_data = word;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        wb_data = alu_result;
        if (mem_ren & ~mem_wen)
            wb_data = ld_data;
        else if (csr_sel)
            wb_data = csr_data;
    end

    assign bus.lsu_data = {wb_data, rd, reg_wen};
endmodule

// File: doc/lsu.md
# lsu

Load/store stage of the multi-cycle NPC core, directly downstream of the execute stage and upstream of writeback. It accepts one executed instruction per valid/ready handshake and, for loads and stores, runs one transaction on a word-wide request/response memory port. It aligns store data and byte masks, and extracts and extends load data. It then selects the writeback value and presents it to the writeback stage with its own valid/ready handshake.

## Interface
- WIDTH, 32: data/address width; only 32 is supported.
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- exu_valid  in  1  upstream payload valid.
- exu_data  in  108  [107:76] alu_result (address / ALU value); [75:44] rs2_data; [43:41] funct3; [40] mem_ren; [39] mem_wen; [38] reg_wen; [37:33] rd; [32] csr_sel; [31:0] csr_data.
- lsu_ready  out  1  stage can accept a payload.
- lsu_valid  out  1  writeback payload valid.
- lsu_data  out  38  [37:6] wb_data; [5:1] rd; [0] reg_wen.
- wbu_ready  in  1  writeback stage accepts.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  1 = write, 0 = read.
- mem_addr  out  32  full byte address, equal to alu_result.
- mem_wdata  out  32  store data shifted into byte lanes.
- mem_wmask  out  4  byte-lane write enables; 0 for reads.
- mem_resp_valid  in  1  response valid; rdata is valid for reads.
- mem_resp_ready  out  1  stage accepts the response.
- mem_rdata  in  32  aligned read word.

## Operation
- FSM states: S_IDLE, S_REQ, S_RESP, S_OUT.
- lsu_ready = (state == S_IDLE).
- Accept: exu_valid & lsu_ready captures exu_data into an internal register.
  - Next state is S_REQ if mem_ren | mem_wen.
  - Otherwise next state is S_OUT.
- S_REQ: mem_req_valid = 1. All request outputs are driven from the captured register and held stable until mem_req_ready. When mem_req_valid & mem_req_ready, go to S_RESP.
- S_RESP: mem_resp_ready = 1. On mem_resp_valid, latch mem_rdata and go to S_OUT.
- S_OUT: lsu_valid = 1 and lsu_data is held stable. When wbu_ready, go to S_IDLE.
- Store lanes (off = alu_result[1:0]):
  - SB (funct3 000): mask 4'b0001 << off, wdata = rs2[7:0] << 8*off.
  - SH (funct3 001): mask 4'b0011 << off, wdata = rs2[15:0] << 8*off.
  - SW (funct3 010): mask 4'b1111, wdata = rs2.
  - Shifted bits beyond lane 3 are truncated.
  - Any other funct3 on a store gives mask 4'b0000; the transaction is still issued.
- Loads take bytes/halves from mem_rdata >> 8*off:
  - LB (000) sign-extends the byte; LBU (100) zero-extends it.
  - LH (001) sign-extends the half; LHU (101) zero-extends it.
  - LW (010) passes the word unchanged.
  - Any other funct3 gives load data 0.
- No misalignment check or trap is raised.
- wb_data is selected in this order:
  - mem_ren & ~mem_wen: load data.
  - csr_sel: csr_data.
  - otherwise: alu_result.
- rd and reg_wen pass through unchanged from the captured payload.
- mem_ren & mem_wen both set: executed as a store only; wb_data follows the csr_sel/alu_result rule.

## Timing
- Reset values (state S_IDLE):
  - lsu_ready = 1.
  - lsu_valid = 0, mem_req_valid = 0, mem_resp_ready = 0.
  - Captured register and lsu_data = 0.
- Non-memory instruction: accepted at edge N, lsu_valid high in cycle N+1.
- Memory instruction, zero-wait memory:
  - Accepted at edge N.
  - Request handshake in cycle N+1.
  - Response earliest in cycle N+2.
  - lsu_valid in cycle N+3.
- A response is never taken in the same cycle as its request. mem_resp_valid outside S_RESP is ignored.
- Backpressure:
  - lsu_valid is held with stable lsu_data until wbu_ready.
  - lsu_ready stays 0 from acceptance until the cycle after the S_OUT handshake, so the stage holds one instruction at a time.
- rst asserted in any state: the next edge forces S_IDLE and drops any outstanding transaction. A late response arriving after reset is ignored.

## Test plan
- ALU op, exu_data alu_result=0x1234, rd=5, reg_wen=1, csr_sel=0, wbu_ready=1 -> lsu_valid one cycle after accept, lsu_data = {0x1234, 5'd5, 1'b1}; no mem_req_valid.
- SB rs2=0xAABBCCDD, addr=0x80000003 -> mem_wmask=4'b1000, mem_wdata=0xDD000000, mem_req_wen=1; request held while mem_req_ready stalls 3 cycles.
- LB addr=0x80000002, mem_rdata=0x12F45678 -> wb_data=0xFFFFFFF4; LBU on the same data -> 0x000000F4; LH at off 2 -> 0x000012F4.
- CSR op csr_sel=1, csr_data=0xDEAD0000, alu_result=0x1 -> wb_data=0xDEAD0000; wbu_ready low 4 cycles -> lsu_valid and lsu_data stable, lsu_ready=0 throughout.
- LW with mem_resp_valid delayed 5 cycles and a spurious mem_resp_valid during S_REQ -> spurious pulse ignored, wb_data equals the delayed rdata.
- rst pulsed in S_RESP, then a response arrives -> next cycle lsu_ready=1 and lsu_valid=0, the response is ignored, and a following ALU op completes normally.
